trap_ctrl: RTL
==============

// Module: trap_ctrl
// PURPOSE
//  Trap sequencer and write-port arbiter for the machine-mode CSR file. Owns the single CSR write port:
//  forwards EX-stage CSR writes when idle; on ecall/mret/timer IRQ, holds the pipeline and issues
//  mepc/mcause/mstatus writes one per cycle, then redirects the PC. Sits between EX and csr_regs.
// PARAMETERS
//  XLEN        64                      data width
//  ECALL_CAUSE 64'd11                  mcause value for ecall from M-mode
//  IRQ_CAUSE   64'h8000_0000_0000_0007 mcause value for machine timer interrupt
// PORTS
//  clk              in   1     clock
//  rst              in   1     synchronous reset, active-low
//  ecall_i          in   1     EX: ecall executing (1-cycle pulse)
//  mret_i           in   1     EX: mret executing (1-cycle pulse)
//  inst_addr_i      in   XLEN  EX: PC of the current instruction
//  ex_csr_wen_i     in   1     EX: CSR write enable
//  ex_csr_waddr_i   in   12    EX: CSR write address
//  ex_csr_wdata_i   in   XLEN  EX: CSR write data
//  csr_mstatus_i    in   XLEN  current mstatus (direct tap from the CSR file)
//  csr_mtvec_i      in   XLEN  current mtvec
//  csr_mepc_i       in   XLEN  current mepc
//  irq_i            in   1     timer interrupt request, level (used only with TIMER_IRQ_EN)
//  csr_wen_o        out  1     CSR file write enable
//  csr_waddr_o      out  12    CSR file write address
//  csr_wdata_o      out  XLEN  CSR file write data
//  hold_flag_o      out  1     stall IF/ID/EX
//  jump_flag_o      out  1     PC redirect, 1-cycle pulse
//  jump_addr_o      out  XLEN  PC redirect target
// BEHAVIOUR
//  - CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342. MIE = bit 3, MPIE = bit 7.
//  - States: IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, T_JUMP, R_MSTATUS, R_JUMP.
//  - IDLE: csr_w*_o = ex_csr_w*_i (combinational pass-through). On ecall_i -> T_MEPC, latching
//    epc = inst_addr_i and cause = ECALL_CAUSE. On mret_i -> R_MSTATUS. hold_flag_o = 1 combinationally
//    in the request cycle. An EX write in the request cycle is still forwarded.
//  - Priority when simultaneous: ecall > mret > irq.
//  - T_MEPC: write mepc = epc. T_MCAUSE: write mcause = cause.
//  - T_MSTATUS: write mstatus with MPIE = csr_mstatus_i[3], MIE = 0, other bits unchanged.
//  - T_JUMP: jump_flag_o = 1, jump_addr_o = {csr_mtvec_i[XLEN-1:2], 2'b00}; next IDLE.
//  - R_MSTATUS: write mstatus with MIE = csr_mstatus_i[7], MPIE = 1, other bits unchanged.
//  - R_JUMP: jump_flag_o = 1, jump_addr_o = csr_mepc_i; next IDLE.
//  - Latency: ecall/irq at cycle N -> writes in N+1..N+3, jump at N+4. mret at N -> write at N+1,
//    jump at N+2.
//  - hold_flag_o = 1 in every non-IDLE state, including the jump cycle.
//  - csr_wen_o = 0 in jump states. EX writes arriving while non-IDLE are dropped.
//  - New ecall/mret/irq while non-IDLE: ignored, not queued.
//  - jump_addr_o = 0 whenever jump_flag_o = 0.
//  - Reset (rst = 0 at a clock edge, any state): state -> IDLE, epc/cause -> 0. While rst = 0 all
//    outputs are 0, including pass-through. A sequence interrupted mid-way is abandoned; no further
//    writes are issued.
// CONFIGURATION
//  - TIMER_IRQ_EN defined: in IDLE with irq_i = 1, csr_mstatus_i[3] = 1 and no ecall_i/mret_i,
//    go to T_MEPC with epc = inst_addr_i (the interrupted instruction is re-executed after mret)
//    and cause = IRQ_CAUSE. The same cycle's EX write is forwarded.
//  - TIMER_IRQ_EN undefined: irq_i is ignored and IRQ_CAUSE is unused.
// TESTING
//  1. IDLE, ex write 0x305 <- 0x8000_0100 -> same cycle csr_wen_o = 1, waddr 0x305, wdata 0x8000_0100;
//     hold 0, jump 0.
//  2. mtvec = 0x8000_0103, mstatus = 0x8, ecall at pc 0x8000_0040 -> N+1 mepc <- 0x8000_0040;
//     N+2 mcause <- 11; N+3 mstatus <- 0x80; N+4 jump to 0x8000_0100; hold high N..N+4.
//  3. mepc = 0x8000_0044, mstatus = 0x80, mret -> N+1 mstatus <- 0x88; N+2 jump to 0x8000_0044;
//     next cycle IDLE, hold 0.
//  4. ecall and mret in the same cycle, plus ex write 0x341 during T_MCAUSE -> ecall sequence only;
//     ex write never reaches csr_wen_o.
//  5. rst low during T_MCAUSE -> all outputs 0. After release: IDLE, no mstatus write, no jump.
//  6. TIMER_IRQ_EN, irq 1, mstatus = 0x8, pc 0x8000_0010 -> mepc 0x8000_0010,
//     mcause 0x8000_0000_0000_0007. With mstatus = 0, or macro undefined -> no sequence starts.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer and sole owner of the CSR write port.
//   Passes EX-stage CSR writes through while idle. On ecall, mret or (with the
//   TIMER_IRQ_EN macro defined) a timer interrupt, it stalls the pipeline and
//   issues the mepc/mcause/mstatus writes one per cycle, then redirects the PC.
//   Ports: clk, rst (sync, active-low); EX side ecall_i, mret_i, inst_addr_i,
//   ex_csr_w{en,addr,data}_i; CSR taps csr_mstatus_i, csr_mtvec_i, csr_mepc_i;
//   irq_i; CSR port csr_w{en,addr,data}_o; pipeline hold_flag_o, jump_flag_o,
//   jump_addr_o.
module trap_ctrl #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] ECALL_CAUSE = 64'd11,
    parameter logic [XLEN-1:0] IRQ_CAUSE   = 64'h8000_0000_0000_0007
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ecall_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] inst_addr_i,
    input  logic            ex_csr_wen_i,
    input  logic [11:0]     ex_csr_waddr_i,
    input  logic [XLEN-1:0] ex_csr_wdata_i,
    input  logic [XLEN-1:0] csr_mstatus_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    input  logic            irq_i,
    output logic            csr_wen_o,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            hold_flag_o,
    output logic            jump_flag_o,
    output logic [XLEN-1:0] jump_addr_o
);
    localparam logic [11:0] MSTATUS = 12'h300;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, T_JUMP, R_MSTATUS, R_JUMP
    } state_t;

    state_t          state, nxt;
    logic [XLEN-1:0] epc, cause, new_cause;
    logic            trap_go;

`ifdef TIMER_IRQ_EN
    // Interrupts are taken only when globally enabled and no instruction event competes.
    assign trap_go   = ecall_i | (irq_i & csr_mstatus_i[3] & ~mret_i);
    assign new_cause = ecall_i ? ECALL_CAUSE : IRQ_CAUSE;
    logic unused_bits;
    assign unused_bits = ^csr_mtvec_i[1:0];
`else
    assign trap_go   = ecall_i;
    assign new_cause = ECALL_CAUSE;
    logic unused_bits;
    assign unused_bits = ^{irq_i, IRQ_CAUSE, csr_mtvec_i[1:0]};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            epc   <= '0;
            cause <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && trap_go) begin
                epc   <= inst_addr_i;
                cause <= new_cause;
            end
        end
    end

    always_comb begin
        nxt         = state;
        csr_wen_o   = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        hold_flag_o = 1'b1;
        jump_flag_o = 1'b0;
        jump_addr_o = '0;
        case (state)
            IDLE: begin
                csr_wen_o   = ex_csr_wen_i;
                csr_waddr_o = ex_csr_waddr_i;
                csr_wdata_o = ex_csr_wdata_i;
                hold_flag_o = trap_go | mret_i;
                nxt         = trap_go ? T_MEPC : (mret_i ? R_MSTATUS : IDLE);
            end
            T_MEPC: begin
                csr_wen_o   = 1'b1;
                csr_waddr_o = MEPC;
                csr_wdata_o = epc;
                nxt         = T_MCAUSE;
            end
            T_MCAUSE: begin
                csr_wen_o   = 1'b1;
                csr_waddr_o = MCAUSE;
                csr_wdata_o = cause;
                nxt         = T_MSTATUS;
            end
            T_MSTATUS: begin
                // MPIE <= MIE, MIE <= 0
                csr_wen_o   = 1'b1;
                csr_waddr_o = MSTATUS;
                csr_wdata_o = csr_mstatus_i;
                csr_wdata_o[7] = csr_mstatus_i[3];
                csr_wdata_o[3] = 1'b0;
                nxt         = T_JUMP;
            end
            T_JUMP: begin
                jump_flag_o = 1'b1;
                jump_addr_o = {csr_mtvec_i[XLEN-1:2], 2'b00};
                nxt         = IDLE;
            end
            R_MSTATUS: begin
                // MIE <= MPIE, MPIE <= 1
                csr_wen_o   = 1'b1;
                csr_waddr_o = MSTATUS;
                csr_wdata_o = csr_mstatus_i;
                csr_wdata_o[3] = csr_mstatus_i[7];
                csr_wdata_o[7] = 1'b1;
                nxt         = R_JUMP;
            end
            R_JUMP: begin
                jump_flag_o = 1'b1;
                jump_addr_o = csr_mepc_i;
                nxt         = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (!rst) begin
            csr_wen_o   = 1'b0;
            csr_waddr_o = '0;
            csr_wdata_o = '0;
            hold_flag_o = 1'b0;
            jump_flag_o = 1'b0;
            jump_addr_o = '0;
        end
    end
endmodule
